// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: evaluates control-flow ops, produces redirect/mispredict results
// behind a valid/ready register, and trains a table of 2-bit prediction counters.
package branch_resolve_pkg;
   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_JAL  = 4'd1,
      OP_JALR = 4'd2,
      OP_BEQ  = 4'd3,
      OP_BNE  = 4'd4,
      OP_BLT  = 4'd5,
      OP_BGE  = 4'd6,
      OP_BLTU = 4'd7,
      OP_BGEU = 4'd8
   } instruction_type;
endpackage

module branch_resolve_unit
   import branch_resolve_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int BHT_ENTRIES = 64,
   parameter int CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  instruction_type       in_op,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [XLEN-1:0]       in_op1,
   input  logic [XLEN-1:0]       in_op2,
   input  logic [XLEN-1:0]       in_target,
   input  logic                  in_pred_taken,
   input  logic [XLEN-1:0]       in_pred_target,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_taken,
   output logic                  out_mispredict,
   output logic [XLEN-1:0]       out_redirect_pc,
   input  logic [XLEN-1:0]       lookup_pc,
   output logic                  lookup_taken,
   output logic [CNT_W-1:0]      stat_branches,
   output logic [CNT_W-1:0]      stat_mispredicts
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic                  is_cond;
   logic                  is_jump;
   logic                  taken;
   logic                  op_eq;
   logic                  op_lt_s;
   logic                  op_lt_u;
   logic [XLEN-1:0]       eff_target;
   logic                  mispredict;
   logic                  accept;
   logic [IDX_W-1:0]      upd_idx;
   logic [IDX_W-1:0]      lookup_idx;

   logic                  out_valid_q, out_valid_d;
   logic                  out_taken_q, out_taken_d;
   logic                  out_mispredict_q, out_mispredict_d;
   logic [XLEN-1:0]       out_redirect_pc_q, out_redirect_pc_d;
   logic [CNT_W-1:0]      stat_br_q, stat_br_d;
   logic [CNT_W-1:0]      stat_mp_q, stat_mp_d;
   logic [1:0]            bht_q [BHT_ENTRIES];
   logic [1:0]            bht_d [BHT_ENTRIES];

   logic                  unused_lookup_bits;

   assign op_eq   = (in_op1 == in_op2);
   assign op_lt_s = ($signed(in_op1) < $signed(in_op2));
   assign op_lt_u = (in_op1 < in_op2);

   always_comb begin
      is_cond = 1'b0;
      is_jump = 1'b0;
      taken   = 1'b0;
      case (in_op)
         OP_JAL, OP_JALR: begin
            is_jump = 1'b1;
            taken   = 1'b1;
         end
         OP_BEQ:  begin is_cond = 1'b1; taken = op_eq;    end
         OP_BNE:  begin is_cond = 1'b1; taken = !op_eq;   end
         OP_BLT:  begin is_cond = 1'b1; taken = op_lt_s;  end
         OP_BGE:  begin is_cond = 1'b1; taken = !op_lt_s; end
         OP_BLTU: begin is_cond = 1'b1; taken = op_lt_u;  end
         OP_BGEU: begin is_cond = 1'b1; taken = !op_lt_u; end
         default: ;
      endcase
   end

   // JALR targets are halfword-aligned by clearing bit 0 of the computed address
   assign eff_target = (in_op == OP_JALR) ? {in_target[XLEN-1:1], 1'b0} : in_target;

   assign mispredict = (taken != in_pred_taken) ||
                       (taken && in_pred_taken && (eff_target != in_pred_target));

   assign in_ready = (!out_valid_q || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   assign upd_idx    = in_pc[IDX_W+1:2];
   assign lookup_idx = lookup_pc[IDX_W+1:2];

   assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

   always_comb begin
      out_valid_d       = out_valid_q;
      out_taken_d       = out_taken_q;
      out_mispredict_d  = out_mispredict_q;
      out_redirect_pc_d = out_redirect_pc_q;
      stat_br_d         = stat_br_q;
      stat_mp_d         = stat_mp_q;
      bht_d             = bht_q;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d       = 1'b1;
         out_taken_d       = taken;
         out_mispredict_d  = mispredict;
         out_redirect_pc_d = taken ? eff_target : in_pc + XLEN'(4);
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end

      // accept is already blocked by flush, so no flush term is needed here
      if (accept && (is_cond || is_jump)) begin
         if (!(&stat_br_q)) stat_br_d = stat_br_q + CNT_W'(1);
         if (mispredict && !(&stat_mp_q)) stat_mp_d = stat_mp_q + CNT_W'(1);
      end

      if (accept && is_cond) begin
         if (taken && (bht_q[upd_idx] != 2'b11)) begin
            bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
         end else if (!taken && (bht_q[upd_idx] != 2'b00)) begin
            bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q       <= 1'b0;
         out_taken_q       <= 1'b0;
         out_mispredict_q  <= 1'b0;
         out_redirect_pc_q <= '0;
         stat_br_q         <= '0;
         stat_mp_q         <= '0;
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         out_valid_q       <= out_valid_d;
         out_taken_q       <= out_taken_d;
         out_mispredict_q  <= out_mispredict_d;
         out_redirect_pc_q <= out_redirect_pc_d;
         stat_br_q         <= stat_br_d;
         stat_mp_q         <= stat_mp_d;
         bht_q             <= bht_d;
      end
   end

   assign out_valid        = out_valid_q;
   assign out_taken        = out_taken_q;
   assign out_mispredict   = out_mispredict_q;
   assign out_redirect_pc  = out_redirect_pc_q;
   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
   assign lookup_taken     = bht_q[lookup_idx][1];

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter XLEN, default 64, datapath and PC width.
REQ-002 Parameter BHT_ENTRIES, default 64, power of two >= 4, number of 2-bit prediction counters.
REQ-003 Parameter CNT_W, default 32, width of the statistics counters.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  resolve request present.
REQ-007 in_ready  output  1  request accepted this cycle when in_valid && in_ready.
REQ-008 in_op  input  instruction_type  operation (JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU; any other value is a non-control op).
REQ-009 in_pc, in_op1, in_op2, in_target  input  XLEN each  instruction PC, compare operands, computed target.
REQ-010 in_pred_taken  input  1  fetch-time prediction; in_pred_target  input  XLEN  fetch-time predicted target.
REQ-011 flush  input  1  pipeline kill.
REQ-012 out_valid  output  1  result held.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_taken, out_mispredict  output  1 each; out_redirect_pc  output  XLEN.
REQ-015 lookup_pc  input  XLEN; lookup_taken  output  1  combinational BHT prediction.
REQ-016 stat_branches, stat_mispredicts  output  CNT_W each.

Function
REQ-017 Taken rule: JAL/JALR always taken; BEQ op1==op2; BNE op1!=op2; BLT/BGE signed <, >=; BLTU/BGEU unsigned <, >=; non-control op never taken.
REQ-018 Effective target = in_target, with bit 0 forced to 0 for JALR.
REQ-019 in_ready = !out_valid || out_ready, forced 0 while flush=1.
REQ-020 On acceptance, the output registers load on the next edge (1-cycle latency): out_valid=1, out_taken, out_redirect_pc = taken ? effective target : in_pc+4 (modulo 2^XLEN).
REQ-021 out_mispredict = (taken != in_pred_taken) || (taken && in_pred_taken && effective target != in_pred_target).
REQ-022 When out_valid && out_ready and no new acceptance occurs, out_valid clears next edge; with simultaneous acceptance, the new result replaces the old with no bubble.
REQ-023 While out_valid && !out_ready, all outputs stay stable.
REQ-024 flush=1 clears out_valid next edge regardless of out_ready; no BHT or statistics update that cycle.
REQ-025 BHT index = pc[log2(BHT_ENTRIES)+1:2] for both lookup and update.
REQ-026 lookup_taken = counter[index(lookup_pc)][1]; no bypass: same-cycle update is visible from the next cycle.
REQ-027 On acceptance of a conditional branch (BEQ..BGEU) only: counter saturating +1 if taken, -1 if not, clamped at 0 and 3.
REQ-028 On every acceptance of JAL, JALR or a conditional branch: stat_branches +1; if mispredict, stat_mispredicts +1; both saturate at all-ones.

Reset
REQ-029 Reset asserted: out_valid=0, out_taken=0, out_mispredict=0, out_redirect_pc=0, statistics=0, all BHT counters=2'b01 (weakly not-taken), effective immediately.
REQ-030 Reset mid-operation discards any held result; first acceptance is allowed on the first edge after deassertion.

Verification
REQ-031 After reset, BEQ pc=0x100, op1=op2=5, target=0x180, pred_taken=0 -> next cycle out_valid=1, out_taken=1, out_mispredict=1, redirect=0x180; lookup_taken(0x100) becomes 1 (counter 01->10).
REQ-032 BLT op1=0xFFFF_FFFF_FFFF_FFFF, op2=1 -> taken; BLTU same operands -> not taken, redirect=pc+4.
REQ-033 JALR target=0x2001, pred_taken=1, pred_target=0x2000 -> taken, redirect=0x2000, mispredict=0, BHT unchanged.
REQ-034 out_ready=0 with out_valid=1 and in_valid=1 for 3 cycles -> in_ready=0, outputs stable; out_ready=1 -> back-to-back acceptance with no bubble.
REQ-035 Four taken branches on one index -> counter saturates at 3; a not-taken branch -> 2, lookup_taken stays 1.
REQ-036 flush during held result plus in_valid -> out_valid=0 next cycle, statistics unchanged; reset pulse mid-stream -> all REQ-029 values at once.
